// File: rtl/melody_sequencer.sv
// Song-RAM driven melody sequencer feeding the square-wave tone generator.
// Optional MELODY_LOOP_EN: restart the song at address 0 on the end marker instead of stopping.
`timescale 1ns / 1ps

module melody_sequencer #(
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned TICK_DIV = 390625
) (
  input  logic              i_clk_25mhz,
  input  logic              i_resetn,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [31:0]       i_wr_data,
  input  logic              i_start,
  input  logic              i_stop,
  output logic [23:0]       o_tone_half_period,
  output logic              o_tone_en,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_play_addr
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam int unsigned TickW = $clog2(TICK_DIV);
  localparam logic [TickW-1:0] TickMax = TickW'(TICK_DIV - 1);

  typedef enum logic [2:0] {StIdle, StFetch, StLoad, StPlay, StDone} state_e;

  state_e            r_state;
  state_e            w_state_d;
  logic [31:0]       r_mem [Depth];
  logic [31:0]       r_rd_data;
  logic [7:0]        w_rd_dur;
  logic [23:0]       w_rd_hp;
  logic [ADDR_W-1:0] r_play_addr;
  logic [TickW-1:0]  r_tick;
  logic [7:0]        r_dur;
  logic [23:0]       r_hp;
  logic              r_en;
  logic              r_done;
  logic              w_restart;
  logic              w_busy;

  // Read port is unconditional; the word for r_play_addr is valid in LOAD.
  always_ff @(posedge i_clk_25mhz) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    r_rd_data <= r_mem[r_play_addr];
  end

  assign w_rd_dur = r_rd_data[31:24];
  assign w_rd_hp  = r_rd_data[23:0];

  always_ff @(posedge i_clk_25mhz) begin
    if (!i_resetn) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_restart = 1'b0;
    case (r_state)
      StIdle:  if (i_start && !i_stop) w_state_d = StFetch;
      StFetch: w_state_d = StLoad;
      StLoad: begin
        if (w_rd_dur == 8'd0) begin
`ifdef MELODY_LOOP_EN
          // An end marker at address 0 means an empty song: stop instead of spinning.
          if (r_play_addr != '0) begin
            w_state_d = StFetch;
            w_restart = 1'b1;
          end else begin
            w_state_d = StDone;
          end
`else
          w_state_d = StDone;
`endif
        end else begin
          w_state_d = StPlay;
        end
      end
      StPlay:  if (r_tick == '0 && r_dur == 8'd1) w_state_d = StFetch;
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
    // DONE is already the terminating cycle, so a stop there must not pulse done twice.
    if (i_stop && r_state != StIdle && r_state != StDone) begin
      w_state_d = StDone;
      w_restart = 1'b0;
    end
  end

  always_comb begin
    w_busy = (r_state != StIdle);
  end

  always_ff @(posedge i_clk_25mhz) begin
    if (!i_resetn) begin
      r_play_addr <= '0;
      r_tick      <= '0;
      r_dur       <= 8'd0;
      r_hp        <= 24'd0;
      r_en        <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= (w_state_d == StDone) || w_restart;
      case (r_state)
        StIdle: begin
          if (w_state_d == StFetch) r_play_addr <= '0;
        end
        StLoad: begin
          if (w_state_d == StPlay) begin
            r_hp   <= w_rd_hp;
            r_en   <= (w_rd_hp != 24'd0);
            r_dur  <= w_rd_dur;
            r_tick <= TickMax;
          end else if (w_restart) begin
            r_play_addr <= '0;
          end
        end
        StPlay: begin
          if (w_state_d != StDone) begin
            if (r_tick == '0) begin
              r_tick <= TickMax;
              r_dur  <= r_dur - 8'd1;
            end else begin
              r_tick <= r_tick - 1'b1;
            end
            // Natural overflow gives the 2**ADDR_W-1 -> 0 wrap.
            if (w_state_d == StFetch) r_play_addr <= r_play_addr + 1'b1;
          end
        end
        default: ;
      endcase
      if (w_state_d == StDone) begin
        r_hp <= 24'd0;
        r_en <= 1'b0;
      end
    end
  end

  assign o_tone_half_period = r_hp;
  assign o_tone_en          = r_en;
  assign o_busy             = w_busy;
  assign o_done             = r_done;
  assign o_play_addr        = r_play_addr;

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed self-checking bench for melody_sequencer (TICK_DIV=4, ADDR_W=4).
// Build with MELODY_LOOP_EN defined to also exercise the looping variant.
`timescale 1ns / 1ps

module tb_melody_sequencer;

  localparam int unsigned AddrW   = 4;
  localparam int unsigned TickDiv = 4;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             wr_en = 1'b0;
  logic [AddrW-1:0] wr_addr = '0;
  logic [31:0]      wr_data = '0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic [23:0]      tone_half_period;
  logic             tone_en;
  logic             busy;
  logic             done;
  logic [AddrW-1:0] play_addr;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  melody_sequencer #(
    .ADDR_W  (AddrW),
    .TICK_DIV(TickDiv)
  ) u_dut (
    .i_clk_25mhz       (clk),
    .i_resetn          (resetn),
    .i_wr_en           (wr_en),
    .i_wr_addr         (wr_addr),
    .i_wr_data         (wr_data),
    .i_start           (start),
    .i_stop            (stop),
    .o_tone_half_period(tone_half_period),
    .o_tone_en         (tone_en),
    .o_busy            (busy),
    .o_done            (done),
    .o_play_addr       (play_addr)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_outs(input string tag, input logic en, input logic [23:0] hp,
                            input logic bsy, input logic dn, input logic [AddrW-1:0] addr);
    check_eq({tag, ".tone_en"}, 32'(tone_en), 32'(en));
    check_eq({tag, ".half_period"}, 32'(tone_half_period), 32'(hp));
    check_eq({tag, ".busy"}, 32'(busy), 32'(bsy));
    check_eq({tag, ".done"}, 32'(done), 32'(dn));
    check_eq({tag, ".play_addr"}, 32'(play_addr), 32'(addr));
  endtask

  task automatic write_entry(input logic [AddrW-1:0] addr, input logic [31:0] data);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = data;
    step();
    wr_en   = 1'b0;
  endtask

  initial begin
    logic             e_en;
    logic [23:0]      e_hp;
    logic [AddrW-1:0] e_addr;

    step_n(2);
    check_outs("reset", 1'b0, 24'd0, 1'b0, 1'b0, '0);
    resetn = 1'b1;
    step();

    write_entry(4'd0, {8'd2, 24'd28409});
    write_entry(4'd1, {8'd1, 24'd0});
    write_entry(4'd2, {8'd0, 24'd0});

    // Song: 8 play cycles + 2 hold, 4 rest + 2 fetch/load, end marker, done, idle.
    // A start pulse mid-note must be ignored.
    start = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      if (c == 0) start = 1'b0;
      if (c == 4) start = 1'b1;
      if (c == 5) start = 1'b0;
      e_en   = (c >= 2 && c < 12);
      e_hp   = e_en ? 24'd28409 : 24'd0;
      e_addr = (c < 10) ? 4'd0 : (c < 16) ? 4'd1 : 4'd2;
      check_outs($sformatf("song.c%0d", c), e_en, e_hp, (c < 19), (c == 18), e_addr);
    end

    // Stop mid-note.
    start = 1'b1;
    step();
    start = 1'b0;
    step_n(4);
    check_outs("stop.pre", 1'b1, 24'd28409, 1'b1, 1'b0, 4'd0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check_outs("stop.done", 1'b0, 24'd0, 1'b1, 1'b1, 4'd0);
    step();
    check_outs("stop.idle", 1'b0, 24'd0, 1'b0, 1'b0, 4'd0);

    // Start and stop together from idle: nothing happens.
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    check_outs("startstop.c0", 1'b0, 24'd0, 1'b0, 1'b0, 4'd0);
    step();
    check_outs("startstop.c1", 1'b0, 24'd0, 1'b0, 1'b0, 4'd0);

`ifdef MELODY_LOOP_EN
    start = 1'b1;
    for (int c = 0; c < 21; c++) begin
      step();
      if (c == 0) start = 1'b0;
      e_en   = (c >= 2 && c < 12) || (c == 20);
      e_hp   = e_en ? 24'd28409 : 24'd0;
      e_addr = (c < 10 || c >= 18) ? 4'd0 : (c < 16) ? 4'd1 : 4'd2;
      check_outs($sformatf("loop.c%0d", c), e_en, e_hp, 1'b1, (c == 18), e_addr);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    check_outs("loop.stop", 1'b0, 24'd0, 1'b1, 1'b1, 4'd0);
    step();
    check_outs("loop.idle", 1'b0, 24'd0, 1'b0, 1'b0, 4'd0);
`endif

    // 16 one-tick notes with no end marker: address wraps 15 -> 0.
    for (int i = 0; i < 16; i++) begin
      write_entry(4'(i), {8'd1, 24'(100 + i)});
    end
    start = 1'b1;
    step();
    start = 1'b0;
    step_n(92);
    check_outs("wrap.n15", 1'b1, 24'd115, 1'b1, 1'b0, 4'd15);
    step_n(4);
    check_outs("wrap.fetch0", 1'b1, 24'd115, 1'b1, 1'b0, 4'd0);
    step_n(2);
    check_outs("wrap.n0", 1'b1, 24'd100, 1'b1, 1'b0, 4'd0);
    step();

    // Reset mid-note: silent idle, no done pulse.
    resetn = 1'b0;
    step();
    check_outs("midreset", 1'b0, 24'd0, 1'b0, 1'b0, 4'd0);
    resetn = 1'b1;
    step();
    check_outs("postreset", 1'b0, 24'd0, 1'b0, 1'b0, 4'd0);

    // RAM survives reset.
    start = 1'b1;
    step();
    start = 1'b0;
    step_n(2);
    check_outs("ramkeep", 1'b1, 24'd100, 1'b1, 1'b0, 4'd0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
